// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column drive, samples synchronized rows,
// and debounces whole-scan results into a one-cycle key strobe plus a held flag.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int WIN   = SETTLE_CYCLES + 2;
  localparam int WIN_W = $clog2(WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic {RELEASED, PRESSED} db_state_t;

  logic [3:0]       row_sync_p0, row_sync_p1;
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       hit_n;
  logic [3:0]       hit_code;
  db_state_t        state;
  logic [3:0]       cnt, cand;

  logic [3:0] closed;
  logic [2:0] cur_n, scan_n_raw;
  logic [1:0] scan_n, col_next;
  logic [3:0] cur_code, scan_code, cnt_inc, rel_cnt;
  logic       sample;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] v);
    logic [1:0] r;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  // Scan accumulation: hit_n saturates at 2 so any second contact marks the scan as MULTI
  always_comb begin
    closed     = ~row_sync_p1;
    cur_n      = pop4(closed);
    cur_code   = key_map(row_of(closed), col_idx);
    scan_n_raw = {1'b0, hit_n} + cur_n;
    scan_n     = (scan_n_raw >= 3'd2) ? 2'd2 : scan_n_raw[1:0];
    scan_code  = (cur_n == 3'd1) ? cur_code : hit_code;
    sample     = (win_cnt == WIN_LAST);
    col_next   = col_idx + 2'd1;
    cnt_inc    = cnt + 4'd1;
    rel_cnt    = (scan_code == cand && cnt != 4'd0) ? cnt_inc : 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_sync_p0   <= 4'b1111;
      row_sync_p1   <= 4'b1111;
      win_cnt       <= '0;
      col_idx       <= 2'd0;
      keyPad_column <= 4'b1110;
      hit_n         <= 2'd0;
      hit_code      <= 4'h0;
      state         <= RELEASED;
      cnt           <= 4'd0;
      cand          <= 4'h0;
      key_code      <= 4'h0;
      key_valid     <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      row_sync_p0 <= keyPad_row;
      row_sync_p1 <= row_sync_p0;
      key_valid   <= 1'b0;
      if (sample) begin
        win_cnt       <= '0;
        col_idx       <= col_next;
        keyPad_column <= ~(4'b0001 << col_next);
        if (col_idx == 2'd3) begin
          hit_n    <= 2'd0;
          hit_code <= 4'h0;
          case (state)
            RELEASED: begin
              if (scan_n == 2'd1) begin
                cand <= scan_code;
                if (rel_cnt == DB_N) begin
                  key_code  <= scan_code;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  cnt       <= 4'd0;
                  state     <= PRESSED;
                end else begin
                  cnt <= rel_cnt;
                end
              end else begin
                cnt <= 4'd0;
              end
            end
            default: begin
              // Any contact while pressed restarts the release count; no rollover to a new key
              if (scan_n == 2'd0) begin
                if (cnt_inc == DB_N) begin
                  key_held <= 1'b0;
                  cnt      <= 4'd0;
                  state    <= RELEASED;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cnt <= 4'd0;
              end
            end
          endcase
        end else begin
          hit_n    <= scan_n;
          hit_code <= scan_code;
        end
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 16-switch keypad model answers the column drive.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic [3:0]  keyPad_row;
  logic [3:0]  keyPad_column;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;
  int lat;

  keypad_scanner #(.SETTLE_CYCLES(2), .DEBOUNCE_SCANS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .keyPad_row   (keyPad_row),
    .keyPad_column(keyPad_column),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  // Key (r,c) occupies bit r*4+c; a closed key pulls its row low while its column is driven low
  function automatic logic [3:0] pad_rows(input logic [3:0] col, input logic [15:0] k);
    logic [3:0] r;
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!col[ci] && k[ri*4+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign keyPad_row = pad_rows(keyPad_column, keys);

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    total++;
    assert (got >= lo && got <= hi) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Land on the negedge right after the column returns to 0 (start of a full scan)
  task automatic align(input string tag);
    int guard = 0;
    while (keyPad_column !== 4'b0111 && guard < 100) begin @(negedge clk); guard++; end
    while (keyPad_column !== 4'b1110 && guard < 100) begin @(negedge clk); guard++; end
    check(tag, guard < 100, 1'b1);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < max) begin @(negedge clk); n++; end
  endtask

  task automatic wait_held_low(input int max, output int n);
    n = 0;
    while (key_held !== 1'b0 && n < max) begin @(negedge clk); n++; end
  endtask

  initial begin
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;

    // Reset and column walk
    keys  = 16'h0000;
    reset = 1'b1;
    tick(3);
    check("rst_column", keyPad_column, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("col_seq_%0d", i), keyPad_column, exp_col[(i / 4) % 4]);
      tick(1);
    end

    // Single press of '5', held 200 cycles
    p0 = pulses;
    align("align_5");
    keys = 16'h1 << 5;
    wait_valid(100, lat);
    check_range("lat_5", lat, 64, 80);
    check("code_5", key_code, 4'h5);
    check("held_5", key_held, 1'b1);
    tick(200 - lat);
    align("align_5_rel");
    keys = 16'h0000;
    wait_held_low(100, lat);
    check_range("rel_lat_5", lat, 64, 80);
    tick(20);
    check("pulses_5", pulses, p0 + 1);
    check("code_5_kept", key_code, 4'h5);

    // Bouncing '#': 2 scans closed, 1 open, five times, then stable
    p0 = pulses;
    align("align_bounce");
    repeat (5) begin
      keys = 16'h1 << 14;
      tick(32);
      keys = 16'h0000;
      tick(16);
    end
    check("bounce_quiet", pulses, p0);
    keys = 16'h1 << 14;
    wait_valid(100, lat);
    check_range("lat_hash", lat, 64, 80);
    check("code_hash", key_code, 4'hF);
    keys = 16'h0000;
    tick(100);
    check("pulses_hash", pulses, p0 + 1);
    check("held_hash_rel", key_held, 1'b0);

    // '1' and '9' together, then '9' released
    p0 = pulses;
    align("align_multi");
    keys = (16'h1 << 0) | (16'h1 << 10);
    tick(200);
    check("multi_quiet", pulses, p0);
    check("multi_held", key_held, 1'b0);
    align("align_multi_rel");
    keys = 16'h1 << 0;
    wait_valid(100, lat);
    check_range("lat_1", lat, 64, 80);
    check("code_1", key_code, 4'h1);
    keys = 16'h0000;
    tick(100);
    check("pulses_1", pulses, p0 + 1);

    // 'A' accepted, slide straight to 'D', then a clean 'D' press
    p0 = pulses;
    align("align_a");
    keys = 16'h1 << 3;
    wait_valid(100, lat);
    check("code_a", key_code, 4'hA);
    keys = 16'h1 << 15;
    tick(200);
    check("slide_no_pulse", pulses, p0 + 1);
    check("slide_held", key_held, 1'b1);
    check("slide_code", key_code, 4'hA);
    keys = 16'h0000;
    tick(100);
    check("slide_released", key_held, 1'b0);
    align("align_d");
    keys = 16'h1 << 15;
    wait_valid(100, lat);
    check_range("lat_d", lat, 64, 80);
    check("code_d", key_code, 4'hD);
    keys = 16'h0000;
    tick(100);
    check("pulses_d", pulses, p0 + 2);

    // '*' accepted, then reset while still held
    align("align_star");
    keys = 16'h1 << 12;
    wait_valid(100, lat);
    check("code_star", key_code, 4'hE);
    tick(5);
    reset = 1'b1;
    tick(1);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_column", keyPad_column, 4'b1110);
    reset = 1'b0;
    p0 = pulses;
    wait_valid(100, lat);
    check_range("lat_star_again", lat, 64, 80);
    check("code_star_again", key_code, 4'hE);
    tick(50);
    check("pulses_star_again", pulses, p0 + 1);
    keys = 16'h0000;
    tick(100);
    check("star_released", key_held, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
